// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and constants for the streaming NTT matrix-vector engine
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  localparam logic [63:0] Q_GOLDILOCKS = 64'hFFFF_FFFF_0000_0001;
  localparam int          DRAIN_CYCLES = 2;

endpackage

// File: rtl/ntt_mac_lane.sv
// rtl/ntt_mac_lane.sv - one modular multiply/reduce/accumulate lane
// Stage 1 registers (x*w) mod Q; stage 2 folds it into the accumulator with one conditional subtract.
module ntt_mac_lane
  import ntt_pkg::*;
#(
  parameter int            DW = 64,
  parameter logic [DW-1:0] Q  = DW'(Q_GOLDILOCKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_w,
  output logic [DW-1:0] o_acc
);

  localparam logic [2*DW-1:0] QW = {{DW{1'b0}}, Q};
  localparam logic [DW:0]     QE = {1'b0, Q};

  logic [2*DW-1:0] w_prod;
  logic [DW:0]     w_sum;
  logic [DW-1:0]   r_p;
  logic            r_pv;
  logic [DW-1:0]   r_acc;

  // Full-width product so operands >= Q are still reduced correctly.
  assign w_prod = {{DW{1'b0}}, i_x} * {{DW{1'b0}}, i_w};
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_p};
  assign o_acc  = r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_p   <= '0;
      r_pv  <= 1'b0;
      r_acc <= '0;
    end else begin
      r_pv <= i_valid;
      if (i_valid) begin
        r_p <= DW'(w_prod % QW);
      end
      if (r_pv) begin
        r_acc <= (w_sum >= QE) ? DW'(w_sum - QE) : w_sum[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/ntt_mv_stream.sv
// rtl/ntt_mv_stream.sv - streaming N-point matrix-vector NTT with valid/ready on both sides
// Owns the IDLE/ACCUM/DRAIN/OUT sequencing, the column counter and the held result register.
module ntt_mv_stream
  import ntt_pkg::*;
#(
  parameter int            N  = 64,
  parameter int            DW = 64,
  parameter logic [DW-1:0] Q  = DW'(Q_GOLDILOCKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         x_in,
  input  logic [N-1:0][DW-1:0]  w_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0][DW-1:0]  y,
  output logic                  busy
);

  localparam int CW = $clog2(N);

  state_t               r_state;
  logic [CW-1:0]        r_col;
  logic [0:0]           r_drain;
  logic                 w_clear;
  logic                 w_accept;
  logic [N-1:0][DW-1:0] w_acc;

  assign w_clear  = (r_state == IDLE) && start;
  assign w_accept = in_valid && in_ready;

  for (genvar j = 0; j < N; j++) begin : g_lane
    ntt_mac_lane #(
      .DW(DW),
      .Q (Q)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clear(w_clear),
      .i_valid(w_accept),
      .i_x    (x_in),
      .i_w    (w_col[j]),
      .o_acc  (w_acc[j])
    );
  end

  // DRAIN covers the two lane pipeline stages so y sees the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_drain   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= ACCUM;
            r_col    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            if (r_col == CW'(N - 1)) begin
              r_state  <= DRAIN;
              r_drain  <= '0;
              in_ready <= 1'b0;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (r_drain == 1'(DRAIN_CYCLES - 1)) begin
            r_state   <= OUT;
            y         <= w_acc;
            out_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_mv_stream.sv
// tb/tb_ntt_mv_stream.sv - randomized self-checking bench for ntt_mv_stream
// A 64-point default instance and a 4-point Q=17 instance, each checked against a full-precision model.
module tb_ntt_mv_stream;

  localparam logic [63:0] BQ = 64'hFFFF_FFFF_0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              b_start = 0, b_in_valid = 0, b_out_ready = 0;
  logic              b_in_ready, b_out_valid, b_busy;
  logic [63:0]       b_x = '0;
  logic [63:0][63:0] b_w = '0;
  logic [63:0][63:0] b_y;
  logic [63:0][63:0] b_exp = '0;
  logic [63:0]       bx [64];
  logic [63:0]       bw [64][64];

  logic              s_start = 0, s_in_valid = 0, s_out_ready = 0;
  logic              s_in_ready, s_out_valid, s_busy;
  logic [7:0]        s_x = '0;
  logic [3:0][7:0]   s_w = '0;
  logic [3:0][7:0]   s_y;
  logic [3:0][7:0]   s_exp = '0;
  logic [7:0]        sx [4];
  logic [7:0]        sw [4][4];

  ntt_mv_stream u_big (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_in(b_x), .w_col(b_w), .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y), .busy(b_busy)
  );

  ntt_mv_stream #(.N(4), .DW(8), .Q(8'd17)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .x_in(s_x), .w_col(s_w), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Whenever a result is presented it must equal the model, every cycle it is held.
  always @(negedge clk) begin
    if (b_out_valid) begin
      n_tests++;
      if (b_y !== b_exp) begin
        n_fail++;
        for (int j = 0; j < 64; j++) begin
          if (b_y[j] !== b_exp[j]) begin
            $display("FAIL big_y lane %0d got %0h expected %0h", j, b_y[j], b_exp[j]);
            break;
          end
        end
      end
    end
    if (s_out_valid) begin
      n_tests++;
      if (s_y !== s_exp) begin
        n_fail++;
        $display("FAIL small_y got %h expected %h", s_y, s_exp);
      end
    end
  end

  task automatic big_model();
    logic [135:0] acc;
    logic [127:0] prod;
    for (int j = 0; j < 64; j++) begin
      acc = '0;
      for (int k = 0; k < 64; k++) begin
        prod = {64'b0, bx[k]} * {64'b0, bw[j][k]};
        acc  = acc + {8'b0, prod};
      end
      b_exp[j] = 64'(acc % {72'b0, BQ});
    end
  endtask

  task automatic small_model();
    int unsigned acc;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) acc += sx[k] * sw[j][k];
      s_exp[j] = 8'(acc % 17);
    end
  endtask

  task automatic big_identity();
    for (int k = 0; k < 64; k++) begin
      bx[k] = 64'(k);
      for (int j = 0; j < 64; j++) bw[j][k] = (j == k) ? 64'd1 : 64'd0;
    end
    big_model();
  endtask

  task automatic big_random();
    for (int k = 0; k < 64; k++) begin
      bx[k] = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) bx[k] = bx[k] % BQ;
      for (int j = 0; j < 64; j++) bw[j][k] = {$urandom, $urandom} % BQ;
    end
    big_model();
  endtask

  // Called at #1 inside the cycle in which start is to be asserted.
  task automatic big_go(input bit stall);
    int t_start, t_last, n, k;
    bit gap;
    b_start = 1; t_start = cyc;
    @(posedge clk); #1;
    b_start = 0;
    chk("big_accum_busy", b_busy, 1);
    k = 0; gap = 0; t_last = 0;
    while (k < 64) begin
      if (stall && gap) begin
        b_in_valid = 0;
        b_x = {$urandom, $urandom};
        for (int j = 0; j < 64; j++) b_w[j] = {$urandom, $urandom};
      end else begin
        chk("big_in_ready", b_in_ready, 1);
        b_in_valid = 1;
        b_x = bx[k];
        for (int j = 0; j < 64; j++) b_w[j] = bw[j][k];
        t_last = cyc;
        k++;
      end
      gap = !gap;
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    chk("big_drain_ready", b_in_ready, 0);
    chk("big_drain_busy", b_busy, 1);
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("big_out_valid", b_out_valid, 1);
    chk("big_lat_last", 64'(cyc - t_last), 3);
    if (!stall) chk("big_lat_start", 64'(cyc - t_start), 67);
  endtask

  task automatic big_release(input int hold);
    for (int i = 0; i < hold; i++) begin
      b_start = 1'($urandom_range(0, 1));
      b_out_ready = 0;
      @(posedge clk); #1;
      chk("bp_out_valid", b_out_valid, 1);
      chk("bp_busy", b_busy, 1);
    end
    b_start = 0;
    b_out_ready = 1;
    @(posedge clk); #1;
    b_out_ready = 0;
    chk("rel_out_valid", b_out_valid, 0);
    chk("rel_busy", b_busy, 0);
    chk("rel_in_ready", b_in_ready, 0);
  endtask

  task automatic small_run();
    int t_last, n;
    small_model();
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int k = 0; k < 4; k++) begin
      chk("small_in_ready", s_in_ready, 1);
      s_in_valid = 1;
      s_x = sx[k];
      for (int j = 0; j < 4; j++) s_w[j] = sw[j][k];
      t_last = cyc;
      @(posedge clk); #1;
    end
    s_in_valid = 0;
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small_out_valid", s_out_valid, 1);
    chk("small_lat_last", 64'(cyc - t_last), 3);
  endtask

  task automatic small_release();
    s_out_ready = 1;
    @(posedge clk); #1;
    s_out_ready = 0;
    chk("small_rel_busy", s_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b_in_ready, 0);
    chk("rst_out_valid", b_out_valid, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_y_nonzero", 64'(b_y != '0), 0);
    chk("rst_small_y", 64'(s_y), 0);
    rst = 0;
    @(posedge clk); #1;

    big_identity();
    big_go(0);
    chk("id_y0", b_y[0], 0);
    chk("id_y5", b_y[5], 5);
    chk("id_y63", b_y[63], 63);
    big_release(10);

    big_go(1);
    chk("stall_y40", b_y[40], 40);
    big_release(0);

    big_random();
    for (int k = 0; k < 20; k++) begin
      b_start = (k == 0);
      b_in_valid = (k != 0);
      b_x = bx[k];
      for (int j = 0; j < 64; j++) b_w[j] = bw[j][k];
      @(posedge clk); #1;
    end
    b_start = 0;
    b_in_valid = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    b_in_valid = 0;
    chk("abort_in_ready", b_in_ready, 0);
    chk("abort_busy", b_busy, 0);
    chk("abort_y_nonzero", 64'(b_y != '0), 0);
    rst = 1; b_start = 1;
    @(posedge clk); #1;
    rst = 0; b_start = 0;
    chk("rst_start_busy", b_busy, 0);
    @(posedge clk); #1;
    chk("rst_start_no_queue", b_busy, 0);

    big_identity();
    big_go(0);
    chk("fresh_y17", b_y[17], 17);
    big_release(2);

    for (int k = 0; k < 64; k++) begin
      bx[k] = BQ - 1;
      for (int j = 0; j < 64; j++) bw[j][k] = BQ - 1;
    end
    big_model();
    big_go(0);
    chk("qm1_y0", b_y[0], 64);
    big_release(0);

    for (int r = 0; r < 3; r++) begin
      big_random();
      big_go(r == 1);
      big_release($urandom_range(0, 3));
    end

    big_random();
    big_go(0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("out_abort_valid", b_out_valid, 0);
    chk("out_abort_y_nonzero", 64'(b_y != '0), 0);

    for (int k = 0; k < 4; k++) begin
      sx[k] = 8'd16;
      for (int j = 0; j < 4; j++) sw[j][k] = 8'd16;
    end
    small_run();
    chk("red_y2", 64'(s_y[2]), 4);
    small_release();

    for (int k = 0; k < 4; k++) begin
      sx[k] = 8'd255;
      for (int j = 0; j < 4; j++) sw[j][k] = 8'd255;
    end
    small_run();
    chk("red255_y1", 64'(s_y[1]), 0);
    small_release();

    for (int k = 0; k < 4; k++) begin
      sx[k] = (k == 0) ? 8'd18 : 8'd0;
      for (int j = 0; j < 4; j++) sw[j][k] = 8'(j + 1);
    end
    small_run();
    chk("red18_y3", 64'(s_y[3]), 4);
    small_release();

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++) begin
        sx[k] = 8'($urandom);
        for (int j = 0; j < 4; j++) sw[j][k] = 8'($urandom);
      end
      small_run();
      small_release();
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
